// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller: tear-free value update,
// shared hex decode, per-digit blank/blink/decimal-point control and dead time.
module seg_scan_ctrl #(
  parameter int unsigned ON_CYC       = 99000,
  parameter int unsigned DEAD_CYC     = 1000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        upd_valid,
  input  logic [15:0] upd_value,
  output logic        upd_ready,
  output logic        upd_done,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned MAX_CYC = (ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC;
  localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DEAD,
    ST_ON
  } state_t;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0:    hex2seg = 7'h40;
      4'h1:    hex2seg = 7'h79;
      4'h2:    hex2seg = 7'h24;
      4'h3:    hex2seg = 7'h30;
      4'h4:    hex2seg = 7'h19;
      4'h5:    hex2seg = 7'h12;
      4'h6:    hex2seg = 7'h02;
      4'h7:    hex2seg = 7'h78;
      4'h8:    hex2seg = 7'h00;
      4'h9:    hex2seg = 7'h10;
      4'hA:    hex2seg = 7'h08;
      4'hB:    hex2seg = 7'h03;
      4'hC:    hex2seg = 7'h46;
      4'hD:    hex2seg = 7'h21;
      4'hE:    hex2seg = 7'h06;
      default: hex2seg = 7'h0E;
    endcase
  endfunction

  state_t        state, state_n;
  logic [1:0]    dig_idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          blink_off, blink_off_n;
  logic [15:0]   disp_val, val_n;
  logic [15:0]   shadow;
  logic          pending;
  logic          frame_n, commit, xfer, dark_n;
  logic [3:0]    nib_n;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  assign upd_ready = ~pending;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_n = state;
    idx_n   = dig_idx;
    cnt_n   = cnt;
    frame_n = 1'b0;
    if (!enable) begin
      state_n = ST_OFF;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_n = ST_DEAD;
          idx_n   = '0;
          cnt_n   = '0;
          frame_n = 1'b1;
        end
        ST_DEAD: begin
          if (cnt == DEAD_LAST) begin
            state_n = ST_ON;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_ON: begin
          if (cnt == ON_LAST) begin
            state_n = ST_DEAD;
            idx_n   = dig_idx + 2'd1;
            cnt_n   = '0;
            frame_n = (dig_idx == 2'd3);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = ST_OFF;
      endcase
    end

    // A held value becomes visible at a frame boundary, or right away while dark.
    commit = pending & (frame_n | (state == ST_OFF));
    xfer   = upd_valid & ~pending;
    val_n  = commit ? shadow : disp_val;

    // Blink counts completed frames only; a restart from OFF is not a completed frame.
    blink_cnt_n = blink_cnt;
    blink_off_n = blink_off;
    if (frame_n && (state == ST_ON)) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_n = '0;
        blink_off_n = ~blink_off;
      end else begin
        blink_cnt_n = blink_cnt + 1'b1;
      end
    end

    nib_n  = val_n[{idx_n, 2'b00} +: 4];
    dark_n = blank_mask[idx_n] | (blink_mask[idx_n] & blink_off_n);
    an_n   = 4'hF;
    seg_n  = 7'h7F;
    dp_n   = 1'b1;
    if ((state_n != ST_OFF) && !dark_n) begin
      seg_n = hex2seg(nib_n);
      dp_n  = ~dp_mask[idx_n];
    end
    if (state_n == ST_ON) an_n[idx_n] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      dig_idx     <= '0;
      cnt         <= '0;
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
      disp_val    <= '0;
      pending     <= 1'b0;
      an          <= 4'hF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
      upd_done    <= 1'b0;
    end else begin
      state       <= state_n;
      dig_idx     <= idx_n;
      cnt         <= cnt_n;
      blink_cnt   <= blink_cnt_n;
      blink_off   <= blink_off_n;
      disp_val    <= val_n;
      if (commit)    pending <= 1'b0;
      else if (xfer) pending <= 1'b1;
      an          <= an_n;
      seg         <= seg_n;
      dp          <= dp_n;
      frame_start <= frame_n;
      upd_done    <= commit;
    end
  end

  // NOTE: shadow is a pure data holding register, only read when pending is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (xfer) shadow <= upd_value;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl: a frame-position reference model
// queues expected outputs at each clock; a negedge monitor pops and compares them.
module tb_seg_scan_ctrl;

  localparam int ON_CYC       = 4;
  localparam int DEAD_CYC     = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int DIGIT_P      = ON_CYC + DEAD_CYC;
  localparam int FRAME_P      = 4 * DIGIT_P;

  localparam logic [6:0] HEXMAP [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_value = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  dp_mask = '0;
  logic        upd_ready, upd_done, dp, frame_start;
  logic [3:0]  an;
  logic [6:0]  seg;

  seg_scan_ctrl #(
    .ON_CYC(ON_CYC),
    .DEAD_CYC(DEAD_CYC),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .upd_valid(upd_valid),
    .upd_value(upd_value),
    .upd_ready(upd_ready),
    .upd_done(upd_done),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .dp_mask(dp_mask),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] commit_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, req);
    end
  endtask

  // Reference model: tracks position within the frame and completed frames.
  bit          m_run = 1'b0;
  int          m_t = 0;
  int          m_frames = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_shadow = '0;
  bit          m_pending = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    bit   commit, fs, xfer, dark;
    int   k;
    e = '0;
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_frames = 0; m_disp = '0; m_pending = 0;
      commit_q.delete();
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ready = 1'b1;
    end else begin
      commit = 0;
      fs     = 0;
      xfer   = upd_valid && !m_pending;
      if (!enable) begin
        commit = m_pending && !m_run;
        m_run  = 0;
      end else if (!m_run) begin
        m_run  = 1;
        m_t    = 0;
        fs     = 1;
        commit = m_pending;
      end else begin
        m_t++;
        if (m_t == FRAME_P) begin
          m_t = 0;
          m_frames++;
          fs     = 1;
          commit = m_pending;
        end
      end
      if (commit) begin
        m_disp    = m_shadow;
        m_pending = 0;
      end
      if (xfer) begin
        m_shadow  = upd_value;
        m_pending = 1;
        commit_q.push_back(upd_value);
      end
      e.fs    = fs;
      e.done  = commit;
      e.ready = !m_pending;
      if (!m_run) begin
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        k      = m_t / DIGIT_P;
        dark   = blank_mask[k] || (blink_mask[k] && ((m_frames / BLINK_FRAMES) % 2 == 1));
        e.seg  = dark ? 7'h7F : HEXMAP[m_disp[4*k +: 4]];
        e.dp   = dark ? 1'b1 : !dp_mask[k];
        e.an   = ((m_t % DIGIT_P) >= DEAD_CYC) ? ~(4'b0001 << k) : 4'hF;
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: compares DUT outputs against queued expectations away from the edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] v;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (!rst_n) begin
        e = '0;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ready = 1'b1;
      end
      check("an", 32'(an), 32'(e.an));
      check("seg", 32'(seg), 32'(e.seg));
      check("dp", 32'(dp), 32'(e.dp));
      check("frame_start", 32'(frame_start), 32'(e.fs));
      check("upd_done", 32'(upd_done), 32'(e.done));
      check("upd_ready", 32'(upd_ready), 32'(e.ready));
      if (rst_n && upd_done === 1'b1) begin
        check("done_has_transfer", 32'(commit_q.size() != 0), 32'd1);
        if (commit_q.size() != 0) begin
          v = commit_q.pop_front();
          check("done_digit0_seg", 32'((seg == HEXMAP[v[3:0]]) || (seg == 7'h7F)), 32'd1);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(60);

    // Update offered mid-frame, then a second offer while the first is pending.
    upd_value = 16'h8A51; upd_valid = 1'b1;
    step(1);
    upd_value = 16'h1234;
    step(4);
    upd_valid = 1'b0;
    step(40);
    upd_value = 16'h1234; upd_valid = 1'b1;
    step(1);
    upd_valid = 1'b0;
    step(30);

    // Blink on digit 1 across several frames.
    blink_mask = 4'b0010;
    step(8 * FRAME_P);
    blink_mask = 4'b0000;

    // Blank digit 3, decimal point on digit 0.
    blank_mask = 4'b1000; dp_mask = 4'b0001;
    step(60);
    blank_mask = 4'b0000; dp_mask = 4'b0000;

    // Enable dropped mid-frame with an update arriving while dark.
    step(9);
    enable = 1'b0;
    step(5);
    upd_value = 16'hC0DE; upd_valid = 1'b1;
    step(1);
    upd_valid = 1'b0;
    step(3);
    enable = 1'b1;
    step(40);

    // Reset pulse mid-frame with a value pending.
    upd_value = 16'hBEEF; upd_valid = 1'b1;
    step(1);
    upd_valid = 1'b0;
    step(5);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(40);

    // Random traffic.
    for (int i = 0; i < 900; i++) begin
      upd_valid = ($urandom_range(0, 5) == 0);
      upd_value = 16'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        blank_mask = 4'($urandom);
        blink_mask = 4'($urandom);
        dp_mask    = 4'($urandom);
      end
      if (enable) enable = !($urandom_range(0, 79) == 0);
      else        enable = ($urandom_range(0, 4) == 0);
      if (rst_n) rst_n = !($urandom_range(0, 299) == 0);
      else       rst_n = 1'b1;
      step(1);
    end

    upd_valid = 1'b0;
    rst_n     = 1'b1;
    enable    = 1'b1;
    step(30);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the security device front panel. It takes a 16-bit hex value through a ready/valid update port, holds it tear-free for a whole frame, and sequences one shared hex-to-segment decode path across the four digits. Per-digit blanking, blinking, decimal-point control and anti-ghosting dead time are included. The block sits between the lock/keypad control logic and the board display pins.

## Interface
- ON_CYC, 99000: cycles each digit's anode is driven; must be ≥1.
- DEAD_CYC, 1000: cycles with all anodes off before each digit; must be ≥1.
- BLINK_FRAMES, 125: frames per blink half-period; must be ≥1.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- enable  in  1  1 = scan display; 0 = display dark.
- upd_valid  in  1  new value offered.
- upd_value  in  16  digit k = upd_value[4k+3:4k], digit 0 rightmost.
- upd_ready  out  1  update can be accepted.
- upd_done  out  1  one-cycle pulse when the accepted value becomes visible.
- blank_mask  in  4  bit k=1: digit k always dark.
- blink_mask  in  4  bit k=1: digit k dark during the blink-off phase.
- dp_mask  in  4  bit k=1: decimal point lit on digit k.
- an  out  4  anodes, active-low, an[k] = digit k.
- seg  out  7  cathodes, active-low, seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse on entry to DEAD for digit 0.

## Operation
- Datapath registers: disp_val (16), shadow (16), pending, dig_idx (2), cycle counter, blink counter, blink_off.
- FSM states:
  - OFF: an=4'hF, seg=7'h7F, dp=1.
  - DEAD: an=4'hF; seg/dp already carry the next digit's pattern.
  - ON: an[dig_idx]=0 with the same seg/dp.
- FSM transitions:
  - OFF→DEAD(digit 0) when enable=1.
  - DEAD→ON after DEAD_CYC cycles.
  - ON→DEAD(dig_idx+1, mod 4) after ON_CYC cycles.
  - Any state→OFF when enable=0; dig_idx and the cycle counter clear to 0.
- Decode is the standard active-low hex map:
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78.
  - 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- Digit dark condition: blank_mask[k] | (blink_mask[k] & blink_off). A dark digit drives seg=7'h7F and dp=1; the anode still follows the FSM.
- dp=~dp_mask[k] when the digit is not dark.
- Update handshake:
  - upd_ready = ~pending.
  - Transfer when upd_valid & upd_ready: shadow←upd_value, pending←1.
  - Commit at the next frame start (DEAD-entry for digit 0, including OFF→DEAD): disp_val←shadow, pending←0, upd_done=1.
  - While in OFF, a pending value commits on the cycle after transfer.
- Blink:
  - blink counter increments at each frame_start.
  - On reaching BLINK_FRAMES, the counter clears and blink_off toggles.
  - The counter is held in OFF.
- Masks are sampled live each cycle; they are not latched per frame.

## Timing
- Reset values:
  - State OFF; an=4'hF, seg=7'h7F, dp=1.
  - upd_ready=1, upd_done=0, frame_start=0.
  - disp_val=0, pending=0, blink_off=0, counters=0.
- All outputs are registered; upd_ready is a direct function of pending.
- With enable held 1 at reset release:
  - Cycle 1: DEAD digit 0, frame_start=1.
  - Anode an[0] goes low DEAD_CYC cycles later.
- Digit period = DEAD_CYC+ON_CYC; frame = 4×(DEAD_CYC+ON_CYC).
- Update latency: transfer to upd_done is ≤1 frame. upd_done coincides with frame_start and with seg showing the new digit 0.
- A transfer on the same cycle as frame_start commits at the following frame (shadow not yet loaded).
- enable falling mid-ON: the next cycle is OFF with all outputs dark; no partial digit continues. Pending is kept and committed per the OFF rule.
- Reset mid-operation: all state returns to reset values immediately (async). A pending value is discarded.

## Test plan
- ON_CYC=4, DEAD_CYC=2, enable=1, reset release -> frame_start at cycle 1. an sequence per 6 cycles: 1111×2, 1110×4, then 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4, repeat. seg=7'h40 throughout.
- Same setup, upd_value=16'h8A51 offered mid-frame -> upd_ready drops next cycle. upd_done and frame_start fire together. During ON: digit0 seg=7'h79, digit1 7'h12, digit2 7'h08, digit3 7'h00.
- Second upd_valid while pending -> upd_ready=0 and no transfer. Value accepted only after upd_done.
- BLINK_FRAMES=2, blink_mask=4'b0010 -> digit 1 seg=7'h7F during frames 3-4, 7-8, ….
- blank_mask=4'b1000, dp_mask=4'b0001 -> digit 3 seg=7'h7F and dp=1. Digit 0 dp=0 during its DEAD and ON.
- enable dropped mid-ON then raised; separately, rst_n pulsed mid-frame -> outputs dark next cycle. Restart at DEAD digit 0 with frame_start. After reset, disp_val=0 and pending=0.
